// File: rtl/data_mem_arbiter_if.sv
// Bundle of the CPU, debug and memory-side signals around the data-memory arbiter.
// slave = arbiter view, master = requester/memory environment view.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              cpu_stall;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_done,
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_done,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single data-memory port between CPU (priority) and DBG (fairness-capped).
// Optional grant/stall counters are compiled in with DATA_MEM_ARB_PERF_EN.
module data_mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MEM_LAT  = 1,
  parameter int FAIR_MAX = 4
) (
  input  logic                CLK,
  input  logic                RST,
  data_mem_arbiter_if.slave   bus
`ifdef DATA_MEM_ARB_PERF_EN
  ,
  output logic [15:0]         cpu_grant_cnt,
  output logic [15:0]         dbg_grant_cnt,
  output logic [15:0]         stall_cyc_cnt
`endif
);
  // state  | meaning
  // IDLE   | arbitrate pending requests
  // ACCESS | memory strobes held for MEM_LAT cycles
  // ACK    | one-cycle done pulse to the owner
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);
  localparam logic [3:0] FAIR_LIM = 4'(FAIR_MAX);

  state_t            state;
  logic              owner_dbg;
  logic [3:0]        lat_cnt;
  logic [3:0]        fair_cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              grant_any;
  logic              grant_dbg;

  assign bus.mem_addr  = lat_addr;
  assign bus.mem_wdata = lat_wdata;
  // Gated by RST so the stall request drops the instant reset asserts.
  assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_done & ~RST;

  always_comb begin
    grant_any = 1'b0;
    grant_dbg = 1'b0;
    if (state == IDLE) begin
      grant_any = bus.cpu_req | bus.dbg_req;
      grant_dbg = bus.dbg_req & (~bus.cpu_req | (fair_cnt == FAIR_LIM));
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      owner_dbg     <= 1'b0;
      lat_cnt       <= '0;
      fair_cnt      <= '0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_re    <= 1'b0;
      bus.cpu_done  <= 1'b0;
      bus.dbg_done  <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.dbg_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            state     <= ACCESS;
            lat_cnt   <= LAT_INIT;
            owner_dbg <= grant_dbg;
            if (grant_dbg) begin
              lat_addr   <= bus.dbg_addr;
              lat_wdata  <= bus.dbg_wdata;
              bus.mem_we <= bus.dbg_we;
              bus.mem_re <= ~bus.dbg_we;
              fair_cnt   <= '0;
            end else begin
              lat_addr   <= bus.cpu_addr;
              lat_wdata  <= bus.cpu_wdata;
              bus.mem_we <= bus.cpu_we;
              bus.mem_re <= ~bus.cpu_we;
              if (!bus.dbg_req)
                fair_cnt <= '0;
              else if (fair_cnt != FAIR_LIM)
                fair_cnt <= fair_cnt + 4'd1;
            end
          end
        end
        ACCESS: begin
          if (lat_cnt == 4'd0) begin
            state      <= ACK;
            bus.mem_we <= 1'b0;
            bus.mem_re <= 1'b0;
            if (bus.mem_re) begin
              if (owner_dbg) bus.dbg_rdata <= bus.mem_rdata;
              else           bus.cpu_rdata <= bus.mem_rdata;
            end
            bus.cpu_done <= ~owner_dbg;
            bus.dbg_done <= owner_dbg;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        ACK: begin
          state        <= IDLE;
          bus.cpu_done <= 1'b0;
          bus.dbg_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DATA_MEM_ARB_PERF_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cpu_grant_cnt <= '0;
      dbg_grant_cnt <= '0;
      stall_cyc_cnt <= '0;
    end else begin
      if (grant_any && !grant_dbg && cpu_grant_cnt != 16'hFFFF)
        cpu_grant_cnt <= cpu_grant_cnt + 16'd1;
      if (grant_dbg && dbg_grant_cnt != 16'hFFFF)
        dbg_grant_cnt <= dbg_grant_cnt + 16'd1;
      if (bus.cpu_stall && stall_cyc_cnt != 16'hFFFF)
        stall_cyc_cnt <= stall_cyc_cnt + 16'd1;
    end
  end
`endif
endmodule
